// File: rtl/dds_update_scheduler_pkg.sv
// Shared encodings for the DDS update scheduler: parameter types, FSM states
// and the default DDS address map.
package dds_update_scheduler_pkg;

  typedef enum logic [1:0] {
    P_FREQ  = 2'd0,
    P_PHASE = 2'd1,
    P_AMP   = 2'd2
  } ptype_t;

  localparam int N_TYPES = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int FREQ0_ADDR  = 8;
  localparam int PHASE0_ADDR = 12;
  localparam int AMP0_ADDR   = 16;

  // Successor in the FREQ -> PHASE -> AMP -> FREQ rotation.
  function automatic logic [1:0] rr_next(input logic [1:0] t);
    return (t == 2'd2) ? 2'd0 : t + 2'd1;
  endfunction

endpackage

// File: rtl/dds_update_scheduler_rr_arbiter_3.sv
// Three-request round-robin arbiter; search starts at the type after the
// last grant, and the pointer only moves when update_en is asserted.
module rr_arbiter_3
  import dds_update_scheduler_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic [2:0] req,
  input  logic       update_en,
  output logic [2:0] grant,
  output logic [1:0] grant_idx,
  output logic       any_req
);

  logic [1:0] last_q;
  logic [1:0] first_idx;
  logic [1:0] second_idx;

  // Last grant resets to AMP so the first search after reset begins at FREQ.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      last_q <= 2'(P_AMP);
    end else if (update_en && any_req) begin
      last_q <= grant_idx;
    end
  end

  always_comb begin
    first_idx  = rr_next(last_q);
    second_idx = rr_next(first_idx);
    any_req    = |req;
    if (req[first_idx]) begin
      grant_idx = first_idx;
    end else if (req[second_idx]) begin
      grant_idx = second_idx;
    end else begin
      grant_idx = last_q;
    end
    grant = any_req ? (3'b001 << grant_idx) : 3'b000;
  end

endmodule

// File: rtl/dds_update_scheduler.sv
// Per-channel DDS update scheduler: captures PID words for this DDS, coalesces
// them latest-wins, and issues one write at a time, round-robin by type.
module dds_update_scheduler
  import dds_update_scheduler_pkg::*;
#(
  parameter int W_CHAN     = 5,
  parameter int W_DATA     = 48,
  parameter int W_FREQ     = 48,
  parameter int W_PHASE    = 14,
  parameter int W_AMP      = 10,
  parameter int FREQ_ADDR  = FREQ0_ADDR,
  parameter int PHASE_ADDR = PHASE0_ADDR,
  parameter int AMP_ADDR   = AMP0_ADDR,
  parameter int TIMEOUT    = 4096,
  parameter int W_CNT      = 16
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               dv_in,
  input  logic [W_CHAN-1:0]  chan_in,
  input  logic [W_DATA-1:0]  data_in,
  input  logic               wr_done_in,
  output logic [W_FREQ-1:0]  freq_out,
  output logic [W_PHASE-1:0] phase_out,
  output logic [W_AMP-1:0]   amp_out,
  output logic               freq_dv_out,
  output logic               phase_dv_out,
  output logic               amp_dv_out,
  output logic               busy_out,
  output logic [2:0]         pend_out,
  output logic [W_CNT-1:0]   coalesce_cnt_out,
  output logic               timeout_out
);

  localparam int W_TO = $clog2(TIMEOUT + 1);

  state_t                state;
  logic [W_TO-1:0]       to_cnt;
  logic [N_TYPES-1:0]    cap;
  logic [N_TYPES-1:0]    pend;
  logic [N_TYPES-1:0]    grant;
  logic [N_TYPES-1:0]    issue_sel;
  logic [1:0]            grant_idx;
  logic                  any_req;
  logic                  sel_now;
  logic [W_FREQ-1:0]     pend_freq;
  logic [W_PHASE-1:0]    pend_phase;
  logic [W_AMP-1:0]      pend_amp;

  always_comb begin
    cap = '0;
    if (dv_in) begin
      cap[int'(P_FREQ)]  = (chan_in == W_CHAN'(FREQ_ADDR));
      cap[int'(P_PHASE)] = (chan_in == W_CHAN'(PHASE_ADDR));
      cap[int'(P_AMP)]   = (chan_in == W_CHAN'(AMP_ADDR));
    end
  end

  assign sel_now   = (state == ST_IDLE) && any_req;
  assign issue_sel = sel_now ? grant : '0;
  assign busy_out  = (state != ST_IDLE);
  assign pend_out  = pend;

  rr_arbiter_3 u_arb (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .req       (pend),
    .update_en (sel_now),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // A capture into the type being issued this cycle re-arms its pending flag
  // and is not counted as a coalesce: the old value goes out, the new one waits.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      pend             <= '0;
      pend_freq        <= '0;
      pend_phase       <= '0;
      pend_amp         <= '0;
      coalesce_cnt_out <= '0;
    end else begin
      pend <= cap | (pend & ~issue_sel);
      if (cap[int'(P_FREQ)]) begin
        pend_freq <= data_in[W_FREQ-1:0];
      end
      if (cap[int'(P_PHASE)]) begin
        pend_phase <= data_in[W_PHASE-1:0];
      end
      if (cap[int'(P_AMP)]) begin
        pend_amp <= data_in[W_AMP-1:0];
      end
      if ((|(cap & pend & ~issue_sel)) && (coalesce_cnt_out != '1)) begin
        coalesce_cnt_out <= coalesce_cnt_out + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state        <= ST_IDLE;
      to_cnt       <= '0;
      freq_out     <= '0;
      phase_out    <= '0;
      amp_out      <= '0;
      freq_dv_out  <= 1'b0;
      phase_dv_out <= 1'b0;
      amp_dv_out   <= 1'b0;
      timeout_out  <= 1'b0;
    end else begin
      freq_dv_out  <= 1'b0;
      phase_dv_out <= 1'b0;
      amp_dv_out   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            case (ptype_t'(grant_idx))
              P_FREQ: begin
                freq_out    <= pend_freq;
                freq_dv_out <= 1'b1;
              end
              P_PHASE: begin
                phase_out    <= pend_phase;
                phase_dv_out <= 1'b1;
              end
              P_AMP: begin
                amp_out    <= pend_amp;
                amp_dv_out <= 1'b1;
              end
              default: ;
            endcase
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          to_cnt <= '0;
          state  <= ST_WAIT;
        end
        // The counter indexes WAIT cycles, so the wait lasts TIMEOUT cycles at most.
        ST_WAIT: begin
          if (wr_done_in) begin
            state <= ST_IDLE;
          end else if (to_cnt == W_TO'(TIMEOUT - 1)) begin
            timeout_out <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
